// File: rtl/display_mode_scheduler_pkg.sv
// Shared encodings for the display sequencing controller and the display module.
package display_mode_scheduler_pkg;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_MANUAL    = 3'd1;
  localparam logic [2:0] ST_AUTO      = 3'd2;
  localparam logic [2:0] ST_COUNTDOWN = 3'd3;
  localparam logic [2:0] ST_ALERT     = 3'd4;

  localparam logic [1:0] SRC_PWR  = 2'b00;
  localparam logic [1:0] SRC_WORK = 2'b01;
  localparam logic [1:0] SRC_CD   = 2'b10;

  localparam logic PAGE_MS = 1'b0;
  localparam logic PAGE_HM = 1'b1;

  typedef struct packed {
    logic [1:0] src_sel;
    logic       page_sel;
    logic       disp_en;
    logic       alert;
  } disp_out_t;

  // Resting state once nothing more urgent is pending.
  function automatic logic [2:0] idle_state(input logic auto_en);
    return auto_en ? ST_AUTO : ST_MANUAL;
  endfunction

endpackage

// File: rtl/display_mode_scheduler_if.sv
// Control inputs and display select outputs of the scheduler.
interface display_mode_scheduler_if;
  logic       power_on;
  logic       sw_page;
  logic       sw_source;
  logic       auto_cycle_en;
  logic       cd_active;
  logic       cd_done_pulse;
  logic       alert_ack;
  logic [1:0] src_sel;
  logic       page_sel;
  logic       disp_en;
  logic       alert;

  modport master (
    output power_on, sw_page, sw_source, auto_cycle_en, cd_active, cd_done_pulse, alert_ack,
    input  src_sel, page_sel, disp_en, alert
  );

  modport slave (
    input  power_on, sw_page, sw_source, auto_cycle_en, cd_active, cd_done_pulse, alert_ack,
    output src_sel, page_sel, disp_en, alert
  );
endinterface

// File: rtl/display_mode_scheduler_tick.sv
// Modulo-N tick counter; wrap pulses on the enabled cycle that returns it to 0.
module tick_counter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign wrap = en && (count == LAST);

  // Count while enabled; clear has priority so a restart always begins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= wrap ? '0 : count + W'(1);
  end
endmodule

// File: rtl/display_mode_scheduler.sv
// Chooses time source, page and display enable for the 4-digit display.
module display_mode_scheduler
  import display_mode_scheduler_pkg::*;
#(
  parameter int DWELL_CYC  = 1500,
  parameter int BLINK_HALF = 125,
  parameter int ALERT_TMO  = 5000
) (
  input logic clk_500Hz,
  input logic rst_n,
  display_mode_scheduler_if.slave bus
);
  logic [2:0] state, next_state;
  logic [1:0] step, next_step;
  disp_out_t  out_q, out_d;
  logic       in_auto, in_alert, alert_restart;
  logic       dwell_wrap, blink_wrap, tmo_wrap;

  assign in_auto  = (state == ST_AUTO);
  assign in_alert = (state == ST_ALERT);
  // A fresh expiry pulse inside ALERT restarts the alert as if newly entered.
  assign alert_restart = !in_alert || bus.cd_done_pulse;

  tick_counter #(.N(DWELL_CYC)) u_dwell (
    .clk(clk_500Hz), .rst_n(rst_n), .clr(!in_auto), .en(in_auto), .wrap(dwell_wrap)
  );

  tick_counter #(.N(BLINK_HALF)) u_blink (
    .clk(clk_500Hz), .rst_n(rst_n), .clr(alert_restart), .en(in_alert), .wrap(blink_wrap)
  );

  tick_counter #(.N(ALERT_TMO)) u_timeout (
    .clk(clk_500Hz), .rst_n(rst_n), .clr(alert_restart), .en(in_alert), .wrap(tmo_wrap)
  );

  // Next-state selection following the power > expiry > countdown > idle priority.
  always_comb begin
    next_state = state;
    if (!bus.power_on) begin
      next_state = ST_OFF;
    end else begin
      case (state)
        ST_OFF: next_state = idle_state(bus.auto_cycle_en);
        ST_ALERT: begin
          if (bus.cd_done_pulse)
            next_state = ST_ALERT;
          else if (bus.alert_ack || tmo_wrap)
            next_state = bus.cd_active ? ST_COUNTDOWN : idle_state(bus.auto_cycle_en);
          else
            next_state = ST_ALERT;
        end
        default: begin
          if (bus.cd_done_pulse)
            next_state = ST_ALERT;
          else if (bus.cd_active)
            next_state = ST_COUNTDOWN;
          else
            next_state = idle_state(bus.auto_cycle_en);
        end
      endcase
    end
  end

  // Rotation step is held at 0 outside AUTO so every entry starts at the first page.
  always_comb begin
    next_step = 2'd0;
    if (in_auto)
      next_step = dwell_wrap ? step + 2'd1 : step;
  end

  // Output values for the state being entered, so they appear on the same edge.
  always_comb begin
    out_d = '{src_sel: SRC_PWR, page_sel: PAGE_MS, disp_en: 1'b0, alert: 1'b0};
    case (next_state)
      ST_MANUAL: begin
        out_d.src_sel  = bus.sw_source ? SRC_WORK : SRC_PWR;
        out_d.page_sel = bus.sw_page;
        out_d.disp_en  = 1'b1;
      end
      ST_AUTO: begin
        out_d.src_sel  = next_step[1] ? SRC_WORK : SRC_PWR;
        out_d.page_sel = next_step[0];
        out_d.disp_en  = 1'b1;
      end
      ST_COUNTDOWN: begin
        out_d.src_sel  = SRC_CD;
        out_d.page_sel = bus.sw_page;
        out_d.disp_en  = 1'b1;
      end
      ST_ALERT: begin
        out_d.src_sel  = SRC_CD;
        out_d.page_sel = PAGE_MS;
        out_d.alert    = 1'b1;
        out_d.disp_en  = alert_restart ? 1'b1 : (blink_wrap ? !out_q.disp_en : out_q.disp_en);
      end
      default: ;
    endcase
  end

  // State, rotation step and output registers.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      step  <= 2'd0;
      out_q <= '{src_sel: SRC_PWR, page_sel: PAGE_MS, disp_en: 1'b0, alert: 1'b0};
    end else begin
      state <= next_state;
      step  <= next_step;
      out_q <= out_d;
    end
  end

  assign bus.src_sel  = out_q.src_sel;
  assign bus.page_sel = out_q.page_sel;
  assign bus.disp_en  = out_q.disp_en;
  assign bus.alert    = out_q.alert;
endmodule

// File: doc/display_mode_scheduler.md
# display_mode_scheduler

Sequencing controller for the 4-digit time display. It decides which time source (power-on, working, countdown) and which page (min:sec or hour:min) the display shows, and drives the display enable. It arbitrates between the user switches, an automatic rotation mode, an active countdown, and a blinking countdown-expiry alert. All outputs are registered and feed the display module's source/page selects and its `en` input directly.

## Interface
Parameters:
- `DWELL_CYC`, 1500: cycles per auto-rotation step (3 s at 500 Hz).
- `BLINK_HALF`, 125: cycles per blink half-period (2 Hz blink).
- `ALERT_TMO`, 5000: cycles before the alert self-clears (10 s).

Ports:
- `clk_500Hz`  in  1  system clock, 500 Hz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `power_on`  in  1  system powered; 0 forces OFF.
- `sw_page`  in  1  user page: 0 = min:sec, 1 = hour:min.
- `sw_source`  in  1  user source: 0 = power-on time, 1 = working time.
- `auto_cycle_en`  in  1  enable automatic rotation.
- `cd_active`  in  1  countdown running.
- `cd_done_pulse`  in  1  one-cycle pulse at countdown expiry.
- `alert_ack`  in  1  debounced one-cycle acknowledge pulse.
- `src_sel`  out  2  00 = power-on, 01 = working, 10 = countdown, 11 unused.
- `page_sel`  out  1  0 = min:sec, 1 = hour:min.
- `disp_en`  out  1  display enable (blinks in ALERT).
- `alert`  out  1  high while in ALERT.

## Operation
- States: OFF, MANUAL, AUTO, COUNTDOWN, ALERT. Reset enters OFF.
- Priority, evaluated every cycle, highest first:
  1. `!power_on` → OFF.
  2. `cd_done_pulse` → ALERT.
  3. `cd_active` → COUNTDOWN, from MANUAL or AUTO, or from ALERT on `alert_ack`.
  4. Otherwise `auto_cycle_en` selects AUTO or MANUAL.
- OFF: `src_sel`=00, `page_sel`=0, `disp_en`=0, `alert`=0. Exits to MANUAL or AUTO when `power_on`=1.
- MANUAL: `src_sel`={0,`sw_source`}, `page_sel`=`sw_page`, `disp_en`=1.
- AUTO: 2-bit step cycles through (00,p0) → (00,p1) → (01,p0) → (01,p1) → wrap. Each step lasts `DWELL_CYC` cycles. Entering AUTO resets both step and dwell counter to 0. `disp_en`=1. Switches are ignored.
- COUNTDOWN: `src_sel`=10, `page_sel`=`sw_page`, `disp_en`=1. If `cd_active` falls without `cd_done_pulse` (cancel), return to MANUAL or AUTO.
- ALERT: `src_sel`=10, `page_sel`=0, `alert`=1. `disp_en` starts at 1 and toggles every `BLINK_HALF` cycles.
  - Exit on `alert_ack`, or after `ALERT_TMO` cycles, to COUNTDOWN/AUTO/MANUAL per the priority list.
  - On exit, `disp_en` returns to 1.
- Counters:
  - dwell: 11 b, 0..`DWELL_CYC`-1.
  - blink: 7 b, 0..`BLINK_HALF`-1.
  - timeout: 13 b, 0..`ALERT_TMO`-1.
  - All counters wrap to 0 and clear on state entry.

## Timing
- All outputs are registered. An input change is reflected on outputs at the next rising edge (1-cycle latency).
- Reset values: `src_sel`=00, `page_sel`=0, `disp_en`=0, `alert`=0; all counters 0.
- AUTO step advances on the cycle when dwell = `DWELL_CYC`-1. Outputs change exactly `DWELL_CYC` cycles after AUTO entry.
- ALERT blink: `disp_en` is 1 for cycles 1..125 after entry, then 0 for 126..250, and so on.
- ALERT timeout: exit on the edge where timeout = `ALERT_TMO`-1 (5000 cycles after entry).
- Simultaneous events:
  - `cd_done_pulse` with `alert_ack`: enter ALERT; the ack is ignored.
  - `alert_ack` with timeout expiry: single exit, same destination.
  - `cd_done_pulse` while already in ALERT: restart timeout and blink counters.
  - `power_on` drop with any other event: OFF wins.
- Mid-operation reset: immediate asynchronous return to the reset values.
- `alert_ack` outside ALERT has no effect.

## Structure
- Shared header holds:
  - state encodings (OFF=0, MANUAL=1, AUTO=2, COUNTDOWN=3, ALERT=4; 3 b);
  - `src_sel` codes (`SRC_PWR`, `SRC_WORK`, `SRC_CD`);
  - page codes.
  The display module uses the same `src_sel` constants.
- One sub-module, `tick_counter`: a parameterised modulo-N counter with `clr`, `en` and `wrap` pulse outputs. It is instantiated three times (dwell, blink, timeout).
- The FSM and output registers stay in the top module.

## Test plan
1. Reset held, then released with `power_on`=0 → outputs 00/0/0/0. Raise `power_on`, `sw_source`=1, `sw_page`=1 → next cycle `src_sel`=01, `page_sel`=1, `disp_en`=1.
2. `auto_cycle_en`=1 → (00,0) for 1500 cycles, (00,1) at cycle 1500, (01,0) at 3000, (01,1) at 4500, wrap to (00,0) at 6000.
3. `cd_active`=1 in AUTO → next cycle `src_sel`=10. Drop `cd_active` without a done pulse → AUTO restarts at step (00,0).
4. `cd_done_pulse` → `alert`=1, `page_sel`=0, `disp_en` toggles every 125 cycles. No ack → exit at cycle 5000 with `disp_en`=1.
5. In ALERT, `alert_ack` at cycle 300 → exit next cycle. `alert_ack` plus `cd_done_pulse` in the same cycle from COUNTDOWN → ALERT is entered.
6. Drop `power_on` during ALERT → OFF next cycle, `disp_en`=0. Assert `rst_n`=0 mid-AUTO → outputs go to reset values asynchronously.
